// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering load/store requests after LATENCY wait states
// Ports: clk, rst_n (async active-low)
//   request : req_valid/req_ready handshake; req_we, req_addr (byte address), req_wdata, req_wstrb
//   response: resp_valid/resp_ready handshake; resp_rdata (0 for writes/errors), resp_err (out of range)
module data_mem_responder #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic we_q;
    logic [31:2] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0] wstrb_q;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic in_range, commit, unused_lsbs;
    assign unused_lsbs = ^req_addr[1:0];
    assign idx = addr_q[ADDR_WIDTH+1:2];
    assign in_range = addr_q[31:ADDR_WIDTH+2] == '0;
    assign commit = state == WAIT && cnt == 4'd0;
    // Handshake flags come straight from state, so req_ready never depends on req_valid.
    assign req_ready = state == IDLE;
    assign resp_valid = state == RESP;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && req_valid) ? WAIT :
                    commit                      ? RESP :
                    (resp_valid && resp_ready)  ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'd0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            cnt     <= 4'(LATENCY);
            we_q    <= req_we;
            addr_q  <= req_addr[31:2];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end else if (state == WAIT) begin
            if (!commit) cnt <= cnt - 4'd1;
            else begin
                resp_rdata <= (!we_q && in_range) ? mem[idx] : '0;
                resp_err   <= !in_range;
            end
        end
    end
    // Memory is deliberately not reset; a reset during WAIT clears state, so no commit happens.
    always_ff @(posedge clk) begin
        if (commit && we_q && in_range)
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized check of data_mem_responder against an array reference model
module tb_data_mem_responder;
    localparam int AW  = 5;
    localparam int LAT = 2;
    localparam int DEPTH = 2**AW;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 0, req_we = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0] req_wstrb = 0;
    logic req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic rv0 = 0, we0 = 0, rr0 = 0;
    logic [31:0] a0 = 0, wd0 = 0;
    logic [3:0] st0 = 0;
    logic rdy0, rsv0, err0;
    logic [31:0] rd0;
    int total = 0, bad = 0;
    logic [31:0] model [DEPTH];
    always #5 clk = ~clk;
    data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));
    data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rdy0), .req_we(we0),
        .req_addr(a0), .req_wdata(wd0), .req_wstrb(st0), .resp_valid(rsv0),
        .resp_ready(rr0), .resp_rdata(rd0), .resp_err(err0));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Reference: out of range when address exceeds the array; writes merge enabled bytes by masking.
    task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rd, output logic er);
        int k;
        logic [31:0] m;
        k = int'((addr / 4) % DEPTH);
        er = (addr / (4 * DEPTH)) != 0;
        rd = 0;
        if (!er && we) begin
            for (int i = 0; i < 4; i++) if (strb[i]) begin
                m = 32'hff << (8 * i);
                model[k] = (model[k] & ~m) | (wdata & m);
            end
        end else if (!er) rd = model[k];
    endtask
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold, output logic [31:0] rd, output logic er);
        int n;
        rd = 0;
        er = 0;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb; resp_ready = 0;
        @(posedge clk); #1;
        req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!resp_valid && n < 40);
        chk("latency", n, LAT + 1);
        if (!resp_valid) return;
        rd = resp_rdata;
        er = resp_err;
        repeat (hold) begin
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", resp_err, er);
            chk("hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        chk("handshake_done", resp_valid, 0);
        chk("rdata_kept", resp_rdata, rd);
        resp_ready = 0;
    endtask
    task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rd);
        int n;
        @(negedge clk);
        rv0 = 1; we0 = we; a0 = addr; wd0 = wdata; st0 = 4'hf; rr0 = 1;
        @(posedge clk); #1;
        rv0 = 0;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!rsv0 && n < 40);
        chk("latency0", n, 1);
        rd = rd0;
        @(posedge clk); #1;
        chk("handshake0", rsv0, 0);
    endtask
    initial begin
        logic [31:0] rd, erd, prior;
        logic er, eer;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < DEPTH; i++) begin
            model_op(1, 32'(i * 4), $urandom, 4'hf, erd, eer);
            do_req(1, 32'(i * 4), model[i], 4'hf, 0, rd, er);
            chk("init_err", er, 0);
        end
        model_op(1, 32'h0c, 32'hdeadbeef, 4'hf, erd, eer);
        do_req(1, 32'h0c, 32'hdeadbeef, 4'hf, 0, rd, er);
        chk("wr_err", er, 0);
        chk("wr_rdata", rd, 0);
        do_req(0, 32'h0c, 0, 4'h0, 0, rd, er);
        chk("rd_deadbeef", rd, 32'hdeadbeef);
        model_op(1, 32'h04, 32'h11223344, 4'hf, erd, eer);
        do_req(1, 32'h04, 32'h11223344, 4'hf, 0, rd, er);
        model_op(1, 32'h04, 32'haabbccdd, 4'b0010, erd, eer);
        do_req(1, 32'h04, 32'haabbccdd, 4'b0010, 0, rd, er);
        do_req(0, 32'h04, 0, 4'h0, 0, rd, er);
        chk("strb_0010", rd, 32'h1122cc44);
        do_req(1, 32'h04, 32'hffffffff, 4'b0000, 0, rd, er);
        chk("strb_0000_err", er, 0);
        do_req(0, 32'h04, 0, 4'h0, 0, rd, er);
        chk("strb_0000", rd, 32'h1122cc44);
        do_req(0, 32'h0c, 0, 4'h0, 5, rd, er);
        chk("bp_rdata", rd, 32'hdeadbeef);
        do_req(1, 32'h80, 32'h5, 4'hf, 0, rd, er);
        chk("oor_err", er, 1);
        chk("oor_rdata", rd, 0);
        model_op(0, 32'h00, 0, 0, erd, eer);
        do_req(0, 32'h00, 0, 4'h0, 0, rd, er);
        chk("oor_no_corrupt", rd, erd);
        do_req(0, 32'h0c, 0, 4'h0, 0, rd, er);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_rdata", resp_rdata, 0);
        chk("mid_rst_err", resp_err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        prior = model[2];
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 32'h08; req_wdata = ~prior; req_wstrb = 4'hf;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_resp_valid", resp_valid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        do_req(0, 32'h08, 0, 4'h0, 0, rd, er);
        chk("abort_no_write", rd, prior);
        for (int t = 0; t < 80; t++) begin
            logic w;
            logic [31:0] a, d;
            logic [3:0] s;
            w = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, 4 * DEPTH - 1));
            d = $urandom;
            s = 4'($urandom);
            model_op(w, a, d, s, erd, eer);
            do_req(w, a, d, s, $urandom_range(0, 3), rd, er);
            chk("rand_rdata", rd, erd);
            chk("rand_err", er, eer);
        end
        req0(1, 32'h10, 32'hcafe1234, rd);
        chk("lat0_wr_rdata", rd, 0);
        req0(0, 32'h10, 0, rd);
        chk("lat0_rd", rd, 32'hcafe1234);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory) end of the load/store request interface driven by the pipeline's memory stage.
- Accepts one valid/ready request at a time: a word-addressed read, or a byte-strobed write.
- Inserts a programmable number of wait states, then returns a response on a separate valid/ready channel.
- Replaces the zero-latency combinational data memory when the pipeline is run against a stalling memory model.

Parameters:
ADDR_WIDTH, 5, number of word-index bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits; fixed at 32 for this version
LATENCY, 2, wait cycles inserted between request acceptance and memory commit (0..15)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  write data, byte lanes aligned to word
req_wstrb  input  4  write byte enables; bit i enables lane [8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  read data (full word); 0 for writes and errors
resp_err  output  1  address out of range

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; wait counter=0.
  - Memory array is not reset.
- States: IDLE, WAIT, RESP.
- req_ready=1 only in IDLE; no combinational path from req_valid to req_ready.
- IDLE:
  - Acceptance occurs on a rising edge with req_valid && req_ready.
  - On acceptance: latch we, addr, wdata, wstrb; counter <= LATENCY; go to WAIT.
  - Requester inputs are don't-care after the acceptance edge.
- WAIT:
  - If counter != 0: counter decrements.
  - If counter == 0: commit on that edge and go to RESP.
  - Commit therefore occurs on the (LATENCY+1)-th edge after acceptance.
- Address check:
  - word index = addr[ADDR_WIDTH+1:2].
  - Out of range when any of addr[31:ADDR_WIDTH+2] is nonzero.
- Commit, in range:
  - Write: each lane with wstrb[i]=1 is updated; other lanes unchanged; resp_rdata <= 0.
  - Write with wstrb=0000: no change, normal response.
  - Read: resp_rdata <= mem[index].
  - resp_err <= 0.
- Commit, out of range:
  - No memory write; resp_rdata <= 0; resp_err <= 1.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until handshake.
  - On resp_valid && resp_ready: go to IDLE, resp_valid <= 0.
  - resp_rdata and resp_err keep their last values after handshake.
- Throughput:
  - Minimum LATENCY+3 cycles per request with resp_ready tied high.
  - A new request is never accepted in the handshake cycle.
- Reset mid-operation:
  - Assertion in WAIT abandons the request; an uncommitted write never reaches memory.
  - Assertion in RESP drops the response; completed writes persist.
- Read-after-write: a read accepted after a write's response handshake returns the written data.
- resp_ready asserted while resp_valid=0 has no effect.

Test Plan:
- Reset values: rst_n low 3 cycles mid-run -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 immediately, without waiting for a clock edge.
- Write/read round trip, LATENCY=2, resp_ready=1:
  - Write addr 0x0000000C data 0xDEADBEEF strb 1111 -> resp_valid rises 3 edges after acceptance, resp_err=0.
  - Read addr 0x0C -> resp_rdata=0xDEADBEEF.
- Byte strobes:
  - Word 0x04 holds 0x11223344; write 0xAABBCCDD strb 0010 -> read returns 0x1122CC44.
  - Write strb 0000 -> word unchanged.
- Backpressure:
  - resp_ready low 5 cycles in RESP -> resp_valid, resp_rdata and resp_err constant; req_ready=0 throughout.
  - Response completes on the first cycle with resp_ready high.
- Out of range: write addr 0x00000080 (ADDR_WIDTH=5) data 0x5 -> resp_err=1, resp_rdata=0; read of addr 0x00 shows no corruption.
- Reset mid-write: accept write to 0x08, drop rst_n during WAIT (counter=1) -> after release, read 0x08 returns the prior value; LATENCY=0 build gives resp_valid 1 edge after acceptance.
